// File: rtl/psdsquare_if.sv
// psdsquare_if: start/stop handshake, operand and result bundle for the squarer
interface psdsquare_if #(parameter int NBITS = 16);
    logic               start;
    logic               stop;
    logic [NBITS-1:0]   xin;
    logic               busy;
    logic               done;
    logic [2*NBITS-1:0] sq;
    modport master (output start, stop, xin, input busy, done, sq);
    modport slave  (input start, stop, xin, output busy, done, sq);
endinterface

// File: rtl/psdsquare.sv
// psdsquare: bit-serial shift-and-add squarer, one multiplier bit per clock
module psdsquare #(parameter int NBITS = 16) (
    input logic        clock,
    input logic        reset,
    psdsquare_if.slave bus
);
    localparam int CW = $clog2(NBITS + 1);
    logic [2*NBITS-1:0] mcand_q, mcand_d, acc_q, acc_d, sq_q, sq_d;
    logic [NBITS-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, run, last;
    always_comb begin
        run      = cnt_q != '0;
        last     = cnt_q == CW'(1);
        mcand_d  = bus.start ? {{NBITS{1'b0}}, bus.xin} : run ? mcand_q << 1 : mcand_q;
        mplier_d = bus.start ? bus.xin : run ? mplier_q >> 1 : mplier_q;
        acc_d    = bus.start ? '0 : (run && mplier_q[0]) ? acc_q + mcand_q : acc_q;
        cnt_d    = bus.start ? CW'(NBITS) : run ? cnt_q - CW'(1) : cnt_q;
        busy_d   = bus.start | (run & ~last);
        done_d   = bus.start ? 1'b0 : (run && last) ? 1'b1 : done_q;
        // stop copies the accumulator as it stands, even mid-run
        sq_d     = bus.stop ? acc_q : sq_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sq_q     <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sq_q     <= sq_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sq   = sq_q;
endmodule
